// File: rtl/div_pkg.sv
// Shared defaults, FSM state encoding and the divide-by-zero quotient constant
// for the round-robin divider arbiter.
package div_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_arbiter_rr_if.sv
// Requester/response bundle of the divider arbiter; slave is the arbiter side,
// master is the side that issues requests and consumes results.
interface div_arbiter_rr_if import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_div0;
  logic                  busy;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0, busy
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0, busy
  );

endinterface

// File: rtl/div_core_seq.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, WIDTH cycles
// per operation. done flags the cycle whose clock edge completes the last iteration.
module div_core_seq import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // The kept remainder is always below the divisor, so only the shifted trial
  // value needs the extra bit to cover divisors >= 2^(WIDTH-1).
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
  end

  assign done      = running && (cnt == CW'(WIDTH-1));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
    end else if (running) begin
      running <= !done;
      cnt     <= done ? '0 : cnt + CW'(1);
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/div_arbiter_rr.sv
// Round-robin arbiter in front of one sequential divider; holds the grant state,
// the IDLE/RUN/DONE FSM and the response registers.
module div_arbiter_rr import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input logic           clk,
  input logic           reset,
  div_arbiter_rr_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nx;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant;
  logic             found;
  logic             accept;
  logic             core_start;
  logic             core_done;
  logic             div0_q;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;

  always_comb begin : arbitrate
    logic [IDW-1:0] cand;
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant) + k) % 32'(NREQ));
      if (!found && bus.req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Gating with reset keeps req_ready low while reset is held.
  assign accept       = reset && (state == IDLE) && found;
  assign sel_dividend = bus.req_dividend[32'(grant)*WIDTH +: WIDTH];
  assign sel_divisor  = bus.req_divisor[32'(grant)*WIDTH +: WIDTH];
  assign core_start   = accept && (sel_divisor != '0);

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = core_start ? RUN : DONE;
      RUN:     if (core_done) state_nx = DONE;
      DONE:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ-1);
      div0_q     <= 1'b0;
      dvd_q      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= grant;
        div0_q     <= !core_start;
        dvd_q      <= sel_dividend;
      end
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);

  always_comb begin
    bus.rsp_id        = '0;
    bus.rsp_div0      = 1'b0;
    bus.rsp_quotient  = '0;
    bus.rsp_remainder = '0;
    if (state == DONE) begin
      bus.rsp_id        = last_grant;
      bus.rsp_div0      = div0_q;
      bus.rsp_quotient  = div0_q ? WIDTH'(DIV0_Q) : core_q;
      bus.rsp_remainder = div0_q ? dvd_q : core_r;
    end
  end

  div_core_seq #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

endmodule

// File: tb/tb_div_arbiter_rr.sv
// Scoreboard bench for div_arbiter_rr: a driver predicts grants and pushes expected
// results computed with plain arithmetic; a monitor pops and compares responses.
module tb_div_arbiter_rr;
  import div_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int NREQ  = DEF_NREQ;
  localparam int IDW   = $clog2(NREQ);

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    int    id;
    word_t q;
    word_t r;
    logic  d0;
    int    due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_rr_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  div_arbiter_rr #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  exp_t  sb[$];
  int    glog[$];
  int    gcyc[$];
  logic  pv[NREQ];
  word_t pdvd[NREQ];
  word_t pdvs[NREQ];
  logic [NREQ-1:0] drv_valid;
  int    refill_mode = 0;  // 0: clear after grant, 1: re-request, 2: random
  bit    rand_rdy = 1'b0;
  logic  rdy_fix = 1'b1;
  int    model_last = NREQ-1;
  bit    model_idle = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] v, int last);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit pv_any();
    for (int i = 0; i < NREQ; i++) if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rand_op(output word_t a, output word_t b);
    int sel;
    sel = $urandom_range(0, 7);
    a = {$urandom, $urandom};
    case (sel)
      0:       b = '0;
      1:       b = {$urandom, $urandom} | (word_t'(1) << (WIDTH-1));
      2, 3:    b = word_t'($urandom_range(1, 1000));
      default: b = {$urandom, $urandom} >> $urandom_range(0, WIDTH-1);
    endcase
  endtask

  task automatic put(int i, word_t a, word_t b);
    pv[i]   = 1'b1;
    pdvd[i] = a;
    pdvs[i] = b;
  endtask

  // Driver: applies pending requests, predicts grants, records accepted work.
  initial begin : driver
    int g, a;
    logic [NREQ-1:0] exp_rdy, acc;
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (refill_mode == 2) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pv[i] && $urandom_range(0, 3) == 0) begin
            pv[i] = 1'b1;
            rand_op(pdvd[i], pdvs[i]);
          end else if (pv[i] && $urandom_range(0, 15) == 0) begin
            pv[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        drv_valid[i] = pv[i];
        bus.req_dividend[i*WIDTH +: WIDTH] = pdvd[i];
        bus.req_divisor[i*WIDTH +: WIDTH]  = pdvs[i];
      end
      bus.req_valid = drv_valid;
      bus.rsp_ready = rand_rdy ? ($urandom_range(0, 2) == 0) : rdy_fix;
      @(negedge clk);
      g = (reset && model_idle) ? rr_pick(drv_valid, model_last) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("busy", bus.busy, !model_idle);
      acc = drv_valid & bus.req_ready;
      a = -1;
      for (int i = NREQ-1; i >= 0; i--) if (acc[i]) a = i;
      if (a >= 0) begin
        e.id  = a;
        e.d0  = (pdvs[a] == '0);
        e.q   = e.d0 ? '1 : pdvd[a] / pdvs[a];
        e.r   = e.d0 ? pdvd[a] : pdvd[a] % pdvs[a];
        e.due = cyc + (e.d0 ? 1 : WIDTH + 1);
        sb.push_back(e);
        glog.push_back(a);
        gcyc.push_back(cyc);
        model_last = a;
        model_idle = 1'b0;
        case (refill_mode)
          1: begin
            rand_op(pdvd[a], pdvs[a]);
            if (pdvs[a] == '0) pdvs[a] = 1;
          end
          2: begin
            pv[a] = ($urandom_range(0, 1) == 1);
            rand_op(pdvd[a], pdvs[a]);
          end
          default: pv[a] = 1'b0;
        endcase
      end
      if (bus.rsp_valid && bus.rsp_ready) model_idle = 1'b1;
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (sb.size() != 0 && cyc >= sb[0].due) begin
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      if (bus.rsp_valid) begin
        chk("rsp_id", bus.rsp_id, sb[0].id);
        chk("rsp_quotient", bus.rsp_quotient, sb[0].q);
        chk("rsp_remainder", bus.rsp_remainder, sb[0].r);
        chk("rsp_div0", bus.rsp_div0, sb[0].d0);
        if (bus.rsp_ready) void'(sb.pop_front());
      end else begin
        void'(sb.pop_front());
      end
    end else begin
      chk("rsp_quiet", {bus.rsp_valid, bus.rsp_div0, bus.rsp_id,
                        bus.rsp_quotient, bus.rsp_remainder}, '0);
    end
  end

  task automatic wait_quiet(string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || pv_any() || !model_idle) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({"drain_", nm}, (n >= 3000), 1'b0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n0;
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0;
      pdvd[i] = '0;
      pdvs[i] = '0;
    end
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b1;
    reset = 1'b0;
    put(0, 10, 3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_quiet("single");

    @(posedge clk); #1;
    put(1, '1, 2);
    put(3, '1, word_t'(1) << (WIDTH-1));
    wait_quiet("full_range");

    @(posedge clk); #1;
    put(2, 50, 0);
    wait_quiet("div0");

    @(posedge clk); #1;
    rdy_fix = 1'b0;
    put(0, 1000, 7);
    put(1, 77, 5);
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", bus.rsp_valid, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rdy_fix = 1'b1;
    wait_quiet("backpressure");

    @(posedge clk); #1;
    put(1, {$urandom, $urandom}, 3);
    n0 = glog.size();
    n = 0;
    while (glog.size() == n0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_run_accept", (glog.size() > n0), 1'b1);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    model_idle = 1'b1;
    model_last = NREQ-1;
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_quotient}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (WIDTH + 10) @(posedge clk);
    #1;

    n0 = glog.size();
    refill_mode = 1;
    for (int i = 0; i < NREQ; i++) put(i, word_t'(100 + i), word_t'(3 + i));
    n = 0;
    while (glog.size() < n0 + 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    refill_mode = 0;
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    chk("fair_count", (glog.size() >= n0 + 5), 1'b1);
    if (glog.size() >= n0 + 5) begin
      for (int k = 0; k < 5; k++) chk("fair_order", glog[n0+k], k % NREQ);
      for (int k = 0; k < 4; k++) chk("fair_spacing", gcyc[n0+k+1] - gcyc[n0+k], WIDTH + 2);
    end
    wait_quiet("fairness");

    refill_mode = 2;
    rand_rdy = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    refill_mode = 0;
    rand_rdy = 1'b0;
    rdy_fix = 1'b1;
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    wait_quiet("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter_rr.md
DIV_ARBITER_RR -- requirements
Module: div_arbiter_rr

Interface
REQ-001 Parameter WIDTH, default 64: operand, quotient and remainder width in bits (unsigned).
REQ-002 Parameter NREQ, default 4: number of requester ports.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high in any cycle.
REQ-007 req_dividend  input  NREQ*WIDTH  requester i operand at bits [i*WIDTH +: WIDTH].
REQ-008 req_divisor  input  NREQ*WIDTH  packed the same way as req_dividend.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-012 rsp_quotient  output  WIDTH  quotient.
REQ-013 rsp_remainder  output  WIDTH  remainder.
REQ-014 rsp_div0  output  1  divisor was zero.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE with any req_valid bit high, the block SHALL combinationally grant one requester round-robin, searching from (last_grant+1) mod NREQ upward.
REQ-018 req_ready[g] SHALL be high only in IDLE and only for the granted g; in RUN and DONE all req_ready bits SHALL be 0.
REQ-019 On accept (req_valid[g] & req_ready[g]), the block SHALL latch operands and g and set last_grant=g; a zero divisor goes to DONE, any other divisor goes to RUN.
REQ-020 RUN SHALL execute exactly WIDTH restoring iterations, one quotient bit per cycle, MSB first, then enter DONE.
REQ-021 The partial remainder SHALL be WIDTH+1 bits wide so results are correct for the full unsigned range, including divisor >= 2^(WIDTH-1).
REQ-022 Each iteration SHALL: shift {rem,quo} left by 1; trial-subtract the divisor; keep the difference and set the quotient LSB to 1 if the difference is non-negative, otherwise restore the partial remainder.
REQ-023 Latency: if accept occurs in cycle 0, rsp_valid SHALL be high from cycle WIDTH+1 (nonzero divisor) or from cycle 1 (zero divisor).
REQ-024 Divide-by-zero result SHALL be: quotient all ones, remainder = dividend, rsp_div0=1.
REQ-025 In DONE, rsp_valid=1 and rsp_id/quotient/remainder/div0 SHALL hold stable until rsp_ready is sampled high; the state then returns to IDLE.
REQ-026 A new request SHALL NOT be accepted in the cycle rsp_ready completes a response; the earliest next accept is the following IDLE cycle.
REQ-027 A requester may drop req_valid before it is granted; no state SHALL change in that case.
REQ-028 In any state other than DONE, rsp_valid SHALL be 0 and the rsp_* data outputs SHALL be 0.

Reset
REQ-029 While reset=0, the block SHALL hold: state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), iteration counter=0, all rsp_* outputs=0, busy=0, req_ready=0.
REQ-030 Reset mid-RUN or mid-DONE SHALL abort the operation and discard the result; no response SHALL follow deassertion.

Structure
REQ-031 Package div_pkg SHALL hold: the WIDTH/NREQ defaults, the state encoding (IDLE=0, RUN=1, DONE=2) and the all-ones div0 quotient constant.
REQ-032 The iterative datapath SHALL be the sub-module div_core_seq, with ports start, dividend, divisor, done, quotient, remainder; div_arbiter_rr holds the arbitration, FSM and response registers.

Verification
REQ-033 Single request: req0 with 10/3 -> rsp_id=0, q=3, r=1, div0=0, rsp_valid first high WIDTH+1 cycles after accept.
REQ-034 Fairness: all four requesters hold valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0, with one response per WIDTH+2 cycles.
REQ-035 Full range: 0xFFFF_FFFF_FFFF_FFFF/2 -> q=0x7FFF_FFFF_FFFF_FFFF, r=1; 0xFFFF_FFFF_FFFF_FFFF/0x8000_0000_0000_0000 -> q=1, r=0x7FFF_FFFF_FFFF_FFFF.
REQ-036 Divide by zero: 50/0 on req2 -> rsp_valid in cycle 1, q all ones, r=50, div0=1, rsp_id=2.
REQ-037 Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready all 0; release -> IDLE, next grant in the following cycle.
REQ-038 Reset mid-RUN: assert reset at iteration 20 -> outputs 0 immediately and no response after release; next request grants requester 0.
